// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module  : bcd_pkg
//  Purpose : Shared types, defaults and helper functions for the BCD converter.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to hold the iteration count WIDTH down to 0.
    function automatic int counter_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
//  Module  : bcd_digit_adjust
//  Purpose : Double-dabble digit cell: add 3 when the digit is 5 or more.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // No carry out: inputs never exceed 9, so the result never exceeds 12.
    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bcd_sequential_converter.sv
// ============================================================================
//  Module  : bcd_sequential_converter
//  Purpose : Multi-cycle shift/add-3 binary-to-BCD converter, WIDTH cycles per
//            conversion. Optional macro BCD_OVERRUN_FLAG_EN builds the sticky
//            dropped-write flag.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_sequential_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      binary_number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_number,
    output logic                  overrun
);

    localparam int CW = counter_width(WIDTH);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_check
        $error("bcd_sequential_converter: DIGITS too small for WIDTH");
    end

    state_t                state;
    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   shifted;
    logic [CW-1:0]         count;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .digit_in  (scratch[4*d +: 4]),
            .digit_out (adjusted[4*d +: 4])
        );
    end

    // The scratch MSB drops off; after adjustment it is always zero.
    assign shifted = {adjusted[4*DIGITS-2:0], shift_reg[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_number <= '0;
            scratch    <= '0;
            shift_reg  <= '0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr) begin
                        shift_reg <= binary_number;
                        scratch   <= '0;
                        count     <= CW'(WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= shifted;
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    count     <= count - 1'b1;
                    if (count == CW'(1)) begin
                        bcd_number <= shifted;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_OVERRUN_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (wr && busy) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_sequential_converter.sv
// ============================================================================
//  Module  : tb_bcd_sequential_converter
//  Purpose : Directed self-checking bench for bcd_sequential_converter.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_sequential_converter;

`ifdef BCD_OVERRUN_FLAG_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wr;
    logic [15:0] binary_number;
    logic        busy;
    logic        done;
    logic [19:0] bcd_number;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int lat;
    int busy_cnt;
    int done_cnt;

    bcd_sequential_converter dut (
        .clk           (clk),
        .reset         (reset),
        .wr            (wr),
        .binary_number (binary_number),
        .busy          (busy),
        .done          (done),
        .bcd_number    (bcd_number),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; lat counts edges since acceptance.
    task automatic wait_done();
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v, input logic [19:0] exp);
        wr = 1'b1;
        binary_number = v;
        tick();
        wr = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        wait_done();
        chk({tag, "_latency"}, lat, 16);
        chk({tag, "_bcd"}, bcd_number, exp);
        chk({tag, "_busycycles"}, busy_cnt, 16);
        tick();
        chk({tag, "_donepulse"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        wr = 1'b0;
        binary_number = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_bcd", bcd_number, 20'h00000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_overrun", overrun, 1'b0);

        run_conv("zero", 16'd0, 20'h00000);
        run_conv("max", 16'd65535, 20'h65535);

        // Back-to-back: second write lands in the done cycle.
        wr = 1'b1;
        binary_number = 16'd1234;
        tick();
        wr = 1'b0;
        lat = 0;
        busy_cnt = 1;
        wait_done();
        chk("b2b_first_latency", lat, 16);
        chk("b2b_first_bcd", bcd_number, 20'h01234);
        wr = 1'b1;
        binary_number = 16'd9;
        tick();
        wr = 1'b0;
        chk("b2b_second_accept_busy", busy, 1'b1);
        chk("b2b_second_done_low", done, 1'b0);
        lat = 0;
        wait_done();
        chk("b2b_second_latency", lat, 16);
        chk("b2b_second_bcd", bcd_number, 20'h00009);
        tick();

        // Dropped write five cycles after acceptance.
        wr = 1'b1;
        binary_number = 16'd500;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wr = 1'b1;
        binary_number = 16'd777;
        tick();
        wr = 1'b0;
        chk("drop_overrun", overrun, OVR_EXP);
        chk("drop_busy", busy, 1'b1);
        lat = 5;
        busy_cnt = 0;
        wait_done();
        chk("drop_latency", lat, 16);
        chk("drop_bcd", bcd_number, 20'h00500);
        tick();
        chk("drop_idle_after", busy, 1'b0);
        chk("drop_overrun_sticky", overrun, OVR_EXP);

        // Reset in the middle of a conversion.
        wr = 1'b1;
        binary_number = 16'd4321;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_bcd", bcd_number, 20'h00000);
        chk("abort_overrun", overrun, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_bcd_held", bcd_number, 20'h00000);

        run_conv("after_abort", 16'd42, 20'h00042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
